// File: rtl/axi_w_arbiter_rr_pkg.sv
// Shared AXI node definitions: arbitration states and sizing helpers.
package axi_w_arbiter_rr_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for a port count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/generic_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty depend only on state.
module generic_fifo #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DATA_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned ADDR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DATA_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DATA_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_w_arbiter_rr.sv
// Round-robin AW arbiter with an order FIFO steering W beats to the granted requester.
module axi_w_arbiter_rr
    import axi_w_arbiter_rr_pkg::*;
#(
    parameter int unsigned N_TARG_PORT = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned AW_W        = 64,
    parameter int unsigned W_W         = 72
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_TARG_PORT-1:0]        awvalid_i,
    output logic [N_TARG_PORT-1:0]        awready_o,
    input  logic [N_TARG_PORT*AW_W-1:0]   awpayload_i,
    output logic                          awvalid_o,
    input  logic                          awready_i,
    output logic [AW_W-1:0]               awpayload_o,
    input  logic [N_TARG_PORT-1:0]        wvalid_i,
    input  logic [N_TARG_PORT-1:0]        wlast_i,
    output logic [N_TARG_PORT-1:0]        wready_o,
    input  logic [N_TARG_PORT*W_W-1:0]    wpayload_i,
    output logic                          wvalid_o,
    output logic                          wlast_o,
    input  logic                          wready_i,
    output logic [W_W-1:0]                wpayload_o,
    output logic                          idle_o
);
    localparam int unsigned PTR_W = idx_width(N_TARG_PORT);
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_TARG_PORT - 1);
    localparam logic [SUM_W-1:0] N_SUM     = SUM_W'(N_TARG_PORT);

    arb_state_e             state_q;
    arb_state_e             state_d;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;
    logic [PTR_W-1:0]       win_q;
    logic [PTR_W-1:0]       win_d;
    logic [PTR_W-1:0]       sel;
    logic                   sel_found;
    logic [SUM_W-1:0]       cand_sum;
    logic [PTR_W-1:0]       cand;
    logic [PTR_W-1:0]       winner;
    logic [N_TARG_PORT-1:0] grant_oh;
    logic                   aw_hs;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [N_TARG_PORT-1:0] fifo_rdata;
    logic [N_TARG_PORT-1:0] head;
    logic                   w_pop;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        sel       = rr_ptr_q;
        sel_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (cand_sum >= N_SUM) begin
                cand_sum = cand_sum - N_SUM;
            end
            cand = cand_sum[PTR_W-1:0];
            if (!sel_found && awvalid_i[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    assign winner    = (state_q == ARB_LOCKED) ? win_q : sel;
    assign grant_oh  = N_TARG_PORT'(1) << winner;
    // Reset forces the request low even while requesters hold awvalid_i.
    assign awvalid_o = rst_n & ((state_q == ARB_LOCKED) | ((|awvalid_i) & ~fifo_full));
    assign aw_hs     = awvalid_o & awready_i;
    assign awready_o = aw_hs ? grant_oh : '0;

    always_comb begin
        awpayload_o = '0;
        for (int unsigned k = 0; k < N_TARG_PORT; k++) begin
            if (winner == PTR_W'(k)) begin
                awpayload_o = awpayload_i[k*AW_W +: AW_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (awvalid_o && !awready_i) begin
                    state_d = ARB_LOCKED;
                    win_d   = sel;
                end
            end
            ARB_LOCKED: begin
                if (awready_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (aw_hs) begin
            rr_ptr_d = (winner == LAST_PORT) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
        end
    end

    generic_fifo #(
        .DATA_WIDTH (N_TARG_PORT),
        .DATA_DEPTH (FIFO_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_hs),
        .wdata (grant_oh),
        .pop   (w_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // W path follows the oldest accepted AW; nothing passes while the FIFO is empty.
    assign head     = fifo_empty ? '0 : fifo_rdata;
    assign wvalid_o = |(wvalid_i & head);
    assign wlast_o  = |(wlast_i & head);
    assign wready_o = wready_i ? head : '0;
    assign w_pop    = wvalid_o & wready_i & wlast_o;
    assign idle_o   = fifo_empty & (state_q == ARB_IDLE);

    always_comb begin
        wpayload_o = '0;
        for (int unsigned k = 0; k < N_TARG_PORT; k++) begin
            if (head[k]) begin
                wpayload_o = wpayload_o | wpayload_i[k*W_W +: W_W];
            end
        end
    end

endmodule

// File: doc/axi_w_arbiter_rr.md
AXI_W_ARBITER_RR -- requirements
Module: axi_w_arbiter_rr

Interface
REQ-001 SHALL have parameter N_TARG_PORT, default 4: number of requesting target ports sharing one initiator port.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: maximum accepted AW bursts whose W data is not yet complete.
REQ-003 SHALL have parameter AW_W, default 64: opaque AW payload width (address/id/len/size/burst, not interpreted).
REQ-004 SHALL have parameter W_W, default 72: opaque W payload width (data/strb/user, wlast carried separately).
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports awvalid_i / awready_o, input / output, N_TARG_PORT each: per-requester AW handshake.
REQ-008 SHALL have port awpayload_i, input, N_TARG_PORT*AW_W: requester k's payload in slice k.
REQ-009 SHALL have ports awvalid_o / awready_i / awpayload_o, output / input / output, 1 / 1 / AW_W: AW toward initiator.
REQ-010 SHALL have ports wvalid_i / wlast_i / wready_o, input / input / output, N_TARG_PORT each: per-requester W handshake.
REQ-011 SHALL have port wpayload_i, input, N_TARG_PORT*W_W: requester k's W payload in slice k.
REQ-012 SHALL have ports wvalid_o / wlast_o / wready_i / wpayload_o, output / output / input / output, 1 / 1 / 1 / W_W: W toward initiator.
REQ-013 SHALL have port idle_o, output, 1: high when order FIFO empty and AW not locked.

Function
REQ-014 AW arbitration SHALL be round-robin: search awvalid_i starting at rr_ptr, ascending, wrapping N_TARG_PORT-1 -> 0.
REQ-015 States: IDLE (selection recomputed each cycle), LOCKED (selection frozen).
REQ-016 awvalid_o SHALL equal any(awvalid_i) AND order FIFO not full; awpayload_o SHALL equal the winner's slice.
REQ-017 IDLE -> LOCKED when awvalid_o=1 and awready_i=0; winner index registered.
REQ-018 In LOCKED, selection and awpayload_o SHALL be held regardless of other requesters' awvalid_i, and awvalid_o held at 1, until awready_i=1.
REQ-019 On awvalid_o & awready_i: awready_o[winner]=1 (combinational, same cycle), all other awready_o=0; push one-hot winner into order FIFO; rr_ptr <= winner+1 mod N_TARG_PORT; state -> IDLE.
REQ-020 awready_o SHALL be all-zero in any cycle without an AW handshake.
REQ-021 FIFO full: awvalid_o=0 and no push, even if a pop occurs the same cycle (new space is usable from the next cycle).
REQ-022 W routing SHALL follow FIFO head: wvalid_o = fifo_valid & wvalid_i[head]; wlast_o, wpayload_o from head slice; wready_o[k] = wready_i & fifo_valid & head[k].
REQ-023 FIFO empty: wvalid_o=0, wready_o all-zero; W beats are never forwarded before their AW is accepted.
REQ-024 First W beat of a burst SHALL be forwardable no earlier than the cycle after its AW handshake (no bypass).
REQ-025 Pop SHALL occur on wvalid_o & wready_i & wlast_o; simultaneous push and pop with FIFO not full SHALL keep occupancy unchanged.
REQ-026 idle_o SHALL be combinational from FIFO-empty and state==IDLE.

Reset
REQ-027 On rst_n=0 (asynchronous): state=IDLE, rr_ptr=0, winner register=0, FIFO empty; hence awvalid_o=0, awready_o=0, wvalid_o=0, wready_o=0, idle_o=1.
REQ-028 Reset mid-burst SHALL discard all outstanding order entries; no beat is forwarded after release until a new AW handshake.

Structure
REQ-029 Arbitration state enum (IDLE, LOCKED) SHALL reside in the shared AXI node package.
REQ-030 Order FIFO SHALL be one GENERIC_FIFO instance, DATA_WIDTH=N_TARG_PORT, DATA_DEPTH=FIFO_DEPTH; rr_ptr width $clog2(N_TARG_PORT).

Verification
REQ-031 Reset: hold all awvalid_i=1 over reset release -> first grant port 0, then 1,2,3,0 with awready_i=1 every cycle.
REQ-032 Lock: ports 1 and 2 valid, awready_i=0 for 5 cycles, port 1 drops awvalid_i at cycle 2 -> awpayload_o stays port 1's, awvalid_o stays 1; grant to 1 on awready_i.
REQ-033 Ordering: AW from 2 then 0, W from 0 (len 3) presented first -> wready_o[0]=0 until port 2's 4-beat burst completes with wlast; then port 0 drains.
REQ-034 Full: 8 AWs accepted, no W -> awvalid_o=0; pop in cycle T -> awvalid_o=1 at T+1, not T.
REQ-035 Empty/no-bypass: wvalid_i[3]=1 with FIFO empty -> wvalid_o=0; AW handshake port 3 at cycle T -> wvalid_o=1 at T+1.
REQ-036 Async reset asserted with 3 entries outstanding -> outputs zero immediately, idle_o=1 after release.
